time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter_if.sv | 24 ++
 rtl/time_counter.sv | 94 +++++++++
 tb/tb_time_counter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/time_counter_if.sv
// Control inputs and BCD display outputs of the stopwatch time counter.
// The master drives the controls; the slave owns the digits and the wrap pulse.
interface time_counter_if;
  logic       ticker;
  logic       pause;
  logic       adj;
  logic       sel_min;
  logic       clr;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       wrap;

  modport master (
    output ticker, pause, adj, sel_min, clr,
    input  sec_ones, sec_tens, min_ones, min_tens, wrap
  );

  modport slave (
    input  ticker, pause, adj, sel_min, clr,
    output sec_ones, sec_tens, min_ones, min_tens, wrap
  );
endinterface

// File: rtl/time_counter.sv
// MM:SS BCD stopwatch counter stepped once per ticker rising edge; digits update one cycle after the edge.
// No backpressure: an edge that is paused or cleared is dropped, never deferred.
module time_counter (
  input  logic          clk,
  input  logic          rst,
  time_counter_if.slave bus
);

  logic       tick_d;
  logic       tick_rise;
  logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  logic [3:0] sec_ones_nxt, sec_tens_nxt, min_ones_nxt, min_tens_nxt;
  logic       wrap_q, wrap_nxt;
  logic [4:0] inc_so, inc_st, inc_mo, inc_mt;

  // Returns {carry, digit}. The >= compare folds any out-of-range code back to 0.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] top);
    if (d >= top) begin
      bcd_inc = {1'b1, 4'd0};
    end else begin
      bcd_inc = {1'b0, d + 4'd1};
    end
  endfunction

  assign tick_rise = bus.ticker & ~tick_d;

  // Every digit's successor is computed in parallel; the mode only picks which to commit.
  assign inc_so = bcd_inc(sec_ones_q, 4'd9);
  assign inc_st = bcd_inc(sec_tens_q, 4'd5);
  assign inc_mo = bcd_inc(min_ones_q, 4'd9);
  assign inc_mt = bcd_inc(min_tens_q, 4'd9);

  always_comb begin
    sec_ones_nxt = sec_ones_q;
    sec_tens_nxt = sec_tens_q;
    min_ones_nxt = min_ones_q;
    min_tens_nxt = min_tens_q;
    wrap_nxt     = 1'b0;

    if (bus.clr) begin
      sec_ones_nxt = 4'd0;
      sec_tens_nxt = 4'd0;
      min_ones_nxt = 4'd0;
      min_tens_nxt = 4'd0;
    end else if (bus.pause) begin
      // hold
    end else if (tick_rise) begin
      if (bus.adj && bus.sel_min) begin
        min_ones_nxt = inc_mo[3:0];
        if (inc_mo[4]) begin
          min_tens_nxt = inc_mt[3:0];
        end
      end else begin
        // Seconds advance in both run mode and seconds adjust.
        sec_ones_nxt = inc_so[3:0];
        if (inc_so[4]) begin
          sec_tens_nxt = inc_st[3:0];
          if (inc_st[4] && !bus.adj) begin
            min_ones_nxt = inc_mo[3:0];
            if (inc_mo[4]) begin
              min_tens_nxt = inc_mt[3:0];
              wrap_nxt     = inc_mt[4];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d     <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      wrap_q     <= 1'b0;
    end else begin
      tick_d     <= bus.ticker;
      sec_ones_q <= sec_ones_nxt;
      sec_tens_q <= sec_tens_nxt;
      min_ones_q <= min_ones_nxt;
      min_tens_q <= min_tens_nxt;
      wrap_q     <= wrap_nxt;
    end
  end

  assign bus.sec_ones = sec_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.min_ones = min_ones_q;
  assign bus.min_tens = min_tens_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter; display is compared as a 16-bit BCD word MMSS.
module tb_time_counter;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;
  logic wrap_seen;
  logic [15:0] disp;

  time_counter_if bus ();

  time_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign disp = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.ticker = 1'b1;
    cyc();
    bus.ticker = 1'b0;
    cyc();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
  endtask

  // Uses adjust mode to load MM:SS from 00:00.
  task automatic load(input int mm, input int ss);
    do_clr();
    bus.adj     = 1'b1;
    bus.sel_min = 1'b1;
    pulses(mm);
    bus.sel_min = 1'b0;
    pulses(ss);
    bus.adj     = 1'b0;
  endtask

  initial begin
    pass_cnt    = 0;
    chk_cnt     = 0;
    rst         = 1'b0;
    bus.ticker  = 1'b0;
    bus.pause   = 1'b0;
    bus.adj     = 1'b0;
    bus.sel_min = 1'b0;
    bus.clr     = 1'b0;

    // Reset held with ticker toggling
    for (int i = 0; i < 6; i++) begin
      bus.ticker = ~bus.ticker;
      cyc();
      if (i % 2 == 1) check("rst_hold_digits", disp, 16'h0000);
    end
    check("rst_hold_wrap", {15'd0, bus.wrap}, 16'h0000);

    // Release with ticker already high counts as an edge
    bus.ticker = 1'b1;
    rst = 1'b1;
    cyc();
    check("rst_release_edge", disp, 16'h0001);
    bus.ticker = 1'b0;
    cyc();

    // Asynchronous reset between clock edges
    pulses(3);
    check("pre_async", disp, 16'h0004);
    rst = 1'b0;
    #2;
    check("async_clear", disp, 16'h0000);
    rst = 1'b1;
    cyc();

    // Run mode: 59 edges then the 60th carries into minutes
    do_clr();
    pulses(59);
    check("run_59", disp, 16'h0059);
    pulse();
    check("run_60", disp, 16'h0100);

    // Count 01:00 -> 99:59, no wrap expected on the way
    wrap_seen = 1'b0;
    for (int i = 0; i < 5939; i++) begin
      bus.ticker = 1'b1;
      cyc();
      wrap_seen = wrap_seen | bus.wrap;
      bus.ticker = 1'b0;
      cyc();
      wrap_seen = wrap_seen | bus.wrap;
    end
    check("run_9959", disp, 16'h9959);
    check("no_early_wrap", {15'd0, wrap_seen}, 16'h0000);

    // Rollover pulse lasts exactly one cycle
    bus.ticker = 1'b1;
    cyc();
    check("rollover_digits", disp, 16'h0000);
    check("rollover_wrap", {15'd0, bus.wrap}, 16'h0001);
    bus.ticker = 1'b0;
    cyc();
    check("wrap_one_cycle", {15'd0, bus.wrap}, 16'h0000);

    // Adjust seconds at 00:59 wraps without carry
    do_clr();
    pulses(59);
    bus.adj = 1'b1;
    bus.sel_min = 1'b0;
    pulse();
    check("adj_sec_wrap", disp, 16'h0000);
    bus.adj = 1'b0;

    // Adjust seconds at 37:59 leaves minutes alone
    load(37, 59);
    check("load_3759", disp, 16'h3759);
    bus.adj = 1'b1;
    pulse();
    check("adj_sec_keep_min", disp, 16'h3700);
    bus.adj = 1'b0;

    // Adjust minutes at 99:30 wraps, seconds kept, no wrap pulse
    load(99, 30);
    bus.adj = 1'b1;
    bus.sel_min = 1'b1;
    bus.ticker = 1'b1;
    cyc();
    check("adj_min_wrap", disp, 16'h0030);
    check("adj_min_no_wrap", {15'd0, bus.wrap}, 16'h0000);
    bus.ticker = 1'b0;
    cyc();
    bus.adj = 1'b0;
    bus.sel_min = 1'b0;

    // Pause discards edges
    load(12, 34);
    check("load_1234", disp, 16'h1234);
    bus.pause = 1'b1;
    pulses(5);
    check("pause_hold", disp, 16'h1234);
    bus.pause = 1'b0;
    pulse();
    check("pause_release", disp, 16'h1235);

    // Ticker held high counts once
    bus.ticker = 1'b1;
    repeat (100) cyc();
    bus.ticker = 1'b0;
    cyc();
    check("held_high_once", disp, 16'h1236);

    // Clear wins over a coincident edge; tick_d still tracks ticker
    load(45, 12);
    bus.clr = 1'b1;
    bus.ticker = 1'b1;
    cyc();
    check("clr_with_edge", disp, 16'h0000);
    check("clr_no_wrap", {15'd0, bus.wrap}, 16'h0000);
    bus.clr = 1'b0;
    cyc();
    check("clr_edge_consumed", disp, 16'h0000);
    bus.ticker = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
